// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter scheduler.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Terminal count of a WIDTH-bit up-counter.
    function automatic int term_val(input int width);
        return (1 << width) - 1;
    endfunction

    // Cycles in WAIT without seeing TERM before the counter is declared stuck.
    function automatic int wd_limit(input int width);
        return (1 << width) + 1;
    endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin pick and pointer advance for counter_sched.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDXW  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDXW-1:0]  i_ptr,
    input  logic [IDXW-1:0]  i_owner,
    output logic             o_any,
    output logic [N_REQ-1:0] o_grant_oh,
    output logic [IDXW-1:0]  o_grant_idx,
    output logic [IDXW-1:0]  o_next_ptr
);

    // Candidate k is the requester k positions after the pointer, wrapping at N_REQ.
    logic [IDXW-1:0] w_cand_idx [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign w_cand_idx[gi] = IDXW'((int'(i_ptr) + gi) % N_REQ);
        end
    endgenerate

    // First requesting candidate in rotated order wins.
    always_comb begin
        o_any       = 1'b0;
        o_grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_any && i_req[w_cand_idx[k]]) begin
                o_any       = 1'b1;
                o_grant_idx = w_cand_idx[k];
            end
        end
        o_grant_oh = o_any ? (N_REQ'(1) << o_grant_idx) : '0;
    end

    // Pointer moves just past the owner so it has lowest priority next time.
    always_comb begin
        o_next_ptr = (i_owner == IDXW'(N_REQ - 1)) ? '0 : i_owner + 1'b1;
    end

endmodule

// File: rtl/counter_sched.sv
// Round-robin owner of one shared loadable up-counter: load, watch to TERM, report done.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_start,
    input  logic [WIDTH-1:0]       count,
    output logic [N_REQ-1:0]       grant,
    output logic                   load,
    output logic [WIDTH-1:0]       load_data,
    output logic [N_REQ-1:0]       done,
    output logic                   err,
    output logic                   busy
);

    localparam int              IDXW     = $clog2(N_REQ);
    localparam logic [WIDTH-1:0] TERM     = WIDTH'(term_val(WIDTH));
    localparam logic [WIDTH:0]   WD_LIMIT = (WIDTH + 1)'(wd_limit(WIDTH));

    state_t             r_state, w_state_next;
    logic [IDXW-1:0]    r_owner, w_owner_next;
    logic [IDXW-1:0]    r_ptr, w_ptr_next;
    logic [WIDTH:0]     r_wd, w_wd_next;
    logic [N_REQ-1:0]   r_grant, w_grant_next;
    logic [WIDTH-1:0]   r_load_data, w_load_data_next;
    logic [N_REQ-1:0]   r_done, w_done_next;
    logic               r_load, w_load_next;
    logic               r_err, w_err_next;
    logic               r_busy;

    logic               w_any;
    logic [N_REQ-1:0]   w_pick_oh;
    logic [IDXW-1:0]    w_pick_idx;
    logic [IDXW-1:0]    w_adv_ptr;
    logic [WIDTH-1:0]   w_start [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_start
            assign w_start[gi] = req_start[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDXW  (IDXW)
    ) u_arb (
        .i_req       (req),
        .i_ptr       (r_ptr),
        .i_owner     (r_owner),
        .o_any       (w_any),
        .o_grant_oh  (w_pick_oh),
        .o_grant_idx (w_pick_idx),
        .o_next_ptr  (w_adv_ptr)
    );

    // Next-state logic; every exit from an ownership clears grant and moves the pointer.
    always_comb begin
        w_state_next     = r_state;
        w_owner_next     = r_owner;
        w_ptr_next       = r_ptr;
        w_wd_next        = r_wd;
        w_grant_next     = r_grant;
        w_load_data_next = r_load_data;
        w_load_next      = 1'b0;
        w_done_next      = '0;
        w_err_next       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next     = LOAD;
                    w_owner_next     = w_pick_idx;
                    w_grant_next     = w_pick_oh;
                    w_load_data_next = w_start[w_pick_idx];
                    w_load_next      = 1'b1;
                end
            end
            LOAD: begin
                w_wd_next = '0;
                if (!req[r_owner]) begin
                    w_state_next = IDLE;
                    w_grant_next = '0;
                    w_ptr_next   = w_adv_ptr;
                end else begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (!req[r_owner]) begin
                    w_state_next = IDLE;
                    w_grant_next = '0;
                    w_ptr_next   = w_adv_ptr;
                end else if (count == TERM) begin
                    w_state_next = DONE;
                    w_done_next  = r_grant;
                end else if ((r_wd + 1'b1) == WD_LIMIT) begin
                    w_state_next = IDLE;
                    w_err_next   = 1'b1;
                    w_grant_next = '0;
                    w_ptr_next   = w_adv_ptr;
                end else begin
                    w_wd_next = r_wd + 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_grant_next = '0;
                w_ptr_next   = w_adv_ptr;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything without touching the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_wd        <= '0;
            r_grant     <= '0;
            r_load_data <= '0;
            r_load      <= 1'b0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_owner     <= w_owner_next;
            r_ptr       <= w_ptr_next;
            r_wd        <= w_wd_next;
            r_grant     <= w_grant_next;
            r_load_data <= w_load_data_next;
            r_load      <= w_load_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
            r_busy      <= (w_state_next != IDLE);
        end
    end

    assign grant     = r_grant;
    assign load      = r_load;
    assign load_data = r_load_data;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule
